// File: rtl/dcache_wb_pkg.sv
// Shared types and defaults for the data-cache write-back buffer.
package dcache_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_MRD  = 2'd2,
    ST_MWR  = 2'd3
  } wb_state_e;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wb_fifo_cam.sv
// Circular line FIFO with a content-addressed lookup returning the youngest valid match.
module wb_fifo_cam
  import dcache_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PTR_W  = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_ovw,
  input  logic [PTR_W-1:0]  i_ovw_idx,
  input  logic [DATA_W-1:0] i_ovw_data,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_hit,
  output logic [PTR_W-1:0]  o_hit_idx,
  output logic [DATA_W-1:0] o_hit_data,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic              o_full,
  output logic              o_empty
);

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;
  logic [DEPTH-1:0]  w_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_tail] <= i_push_addr;
      r_data[r_tail] <= i_push_data;
    end
    if (i_ovw) begin
      r_data[i_ovw_idx] <= i_ovw_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign w_match[gi] = r_valid[gi] && (r_addr[gi] == i_lookup_addr);
  end

  // Scan oldest to youngest so the last hit seen is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] v_scan;
    o_hit     = 1'b0;
    o_hit_idx = '0;
    v_scan    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_scan = r_head + PTR_W'(i);
      if (w_match[v_scan]) begin
        o_hit     = 1'b1;
        o_hit_idx = v_scan;
      end
    end
  end

  assign o_hit_data  = r_data[o_hit_idx];
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  assign o_full      = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty     = (r_count == '0);

endmodule

// File: rtl/dcache_write_buffer.sv
// Write-back buffer between the data cache and slow memory; reads forward from the buffer.
// Define DCACHE_WB_COALESCE_EN to merge writes to an already-buffered line in place.
module dcache_write_buffer
  import dcache_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ready,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              wb_empty
);

  localparam int PTR_W = ptr_w(DEPTH);

  wb_state_e         r_state, w_state_next;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_next;
  logic [DATA_W-1:0] r_rdata, w_rdata_next;
  logic              w_push, w_pop, w_ovw;
  logic              w_hit, w_coal_hit, w_full, w_empty;
  logic [PTR_W-1:0]  w_hit_idx;
  logic [DATA_W-1:0] w_hit_data, w_head_data;
  logic [ADDR_W-1:0] w_head_addr;

  wb_fifo_cam #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_addr  (c_addr),
    .i_push_data  (c_wdata),
    .i_pop        (w_pop),
    .i_ovw        (w_ovw),
    .i_ovw_idx    (w_hit_idx),
    .i_ovw_data   (c_wdata),
    .i_lookup_addr(c_addr),
    .o_hit        (w_hit),
    .o_hit_idx    (w_hit_idx),
    .o_hit_data   (w_hit_data),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

`ifdef DCACHE_WB_COALESCE_EN
  assign w_coal_hit = w_hit;
`else
  assign w_coal_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rd_addr <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rd_addr <= w_rd_addr_next;
      r_rdata   <= w_rdata_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_rd_addr_next = r_rd_addr;
    w_rdata_next   = r_rdata;
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_ovw          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (c_write) begin
          if (w_coal_hit) begin
            w_ovw        = 1'b1;
            w_state_next = ST_ACK;
          end else if (!w_full) begin
            w_push       = 1'b1;
            w_state_next = ST_ACK;
          end else begin
            w_state_next = ST_MWR;
          end
        end else if (c_read) begin
          // A miss may overtake queued drains since the line is not in the buffer.
          if (w_hit) begin
            w_rdata_next = w_hit_data;
            w_state_next = ST_ACK;
          end else begin
            w_rd_addr_next = c_addr;
            w_state_next   = ST_MRD;
          end
        end else if (!w_empty) begin
          w_state_next = ST_MWR;
        end
      end
      ST_ACK: w_state_next = ST_IDLE;
      ST_MRD: begin
        if (m_ready) begin
          w_rdata_next = m_rdata;
          w_state_next = ST_ACK;
        end
      end
      ST_MWR: begin
        if (m_ready) begin
          w_pop        = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign c_ready  = (r_state == ST_ACK);
  assign c_rdata  = r_rdata;
  assign m_read   = (r_state == ST_MRD);
  assign m_write  = (r_state == ST_MWR);
  assign m_addr   = (r_state == ST_MRD) ? r_rd_addr :
                    (r_state == ST_MWR) ? w_head_addr : '0;
  assign m_wdata  = (r_state == ST_MWR) ? w_head_data : '0;
  assign wb_empty = w_empty;

endmodule
